// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Expand a requester index into its one-hot grant vector.
    function automatic logic [NREQ-1:0] onehot_from_idx(input logic [SEL_W-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: circular first-set search over an 8-bit request vector, starting at ptr.
import mux8_arb_pkg::*;

module rr_pick8 (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    // rot[k] is the request that sits k positions after ptr (modulo 8).
    logic [NREQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            logic [SEL_W-1:0] pos;
            assign pos     = ptr + SEL_W'(gi);
            assign rot[gi] = req[pos];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the first requester at or after ptr.
    always_comb begin
        logic [SEL_W-1:0] offset;
        offset = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = SEL_W'(k);
            end
        end
        found = |rot;
        idx   = ptr + offset;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin owner selection for a shared 8:1 datapath mux.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining MUX8_ARB_PREEMPT_EN.
import mux8_arb_pkg::*;

module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_change
);

    generate
        if (MAX_HOLD < 1 || MAX_HOLD > NREQ || (1 << HOLD_W) < MAX_HOLD) begin : g_bad_param
            $error("mux8_rr_arbiter: MAX_HOLD must be 1..8 and fit in HOLD_W bits");
        end
    endgenerate

    arb_state_t       state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [NREQ-1:0]  gnt_reg, gnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             gnt_valid_reg, gnt_valid_next;
    logic             gnt_change_reg, gnt_change_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    logic [SEL_W-1:0] scan_ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             switch_owner;

    // While idle the scan starts at the stored pointer; while busy the pick is
    // only consumed on a hand-over, where the scan starts just past the owner.
    assign scan_ptr = (state_reg == ARB_BUSY) ? sel_reg + SEL_W'(1) : ptr_reg;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (scan_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef MUX8_ARB_PREEMPT_EN
    logic others_pending;
    assign others_pending = |(req & ~onehot_from_idx(sel_reg));
    // Hand over when the owner lets go, or when it has used its slot and someone else waits.
    assign switch_owner = !req[sel_reg] ||
                          ((hold_cnt_reg == HOLD_W'(MAX_HOLD - 1)) && others_pending);
`else
    // Hand over only when the owner lets go.
    assign switch_owner = !req[sel_reg];
`endif

    // Next-state and next-output decode; gnt_change only pulses when a new owner is granted.
    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        gnt_next        = gnt_reg;
        sel_next        = sel_reg;
        gnt_valid_next  = gnt_valid_reg;
        gnt_change_next = 1'b0;
        hold_cnt_next   = hold_cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_next      = ARB_BUSY;
                    gnt_next        = onehot_from_idx(pick_idx);
                    sel_next        = pick_idx;
                    gnt_valid_next  = 1'b1;
                    gnt_change_next = 1'b1;
                    hold_cnt_next   = '0;
                end
            end
            ARB_BUSY: begin
                if (switch_owner) begin
                    ptr_next = sel_reg + SEL_W'(1);
                    if (pick_found) begin
                        gnt_next        = onehot_from_idx(pick_idx);
                        sel_next        = pick_idx;
                        gnt_change_next = 1'b1;
                        hold_cnt_next   = '0;
                    end else begin
                        // sel keeps its last value so the mux output stays stable.
                        state_next     = ARB_IDLE;
                        gnt_next       = '0;
                        gnt_valid_next = 1'b0;
                        hold_cnt_next  = '0;
                    end
                end else if (hold_cnt_reg != '1) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB_IDLE;
            ptr_reg        <= '0;
            gnt_reg        <= '0;
            sel_reg        <= '0;
            gnt_valid_reg  <= 1'b0;
            gnt_change_reg <= 1'b0;
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            gnt_reg        <= gnt_next;
            sel_reg        <= sel_next;
            gnt_valid_reg  <= gnt_valid_next;
            gnt_change_reg <= gnt_change_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    assign gnt        = gnt_reg;
    assign sel        = sel_reg;
    assign gnt_valid  = gnt_valid_reg;
    assign gnt_change = gnt_change_reg;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a driver applies directed request vectors and
// queues the hand-computed response; a monitor pops and compares one entry per clock.
module tb_mux8_rr_arbiter;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       change;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] sel;
    logic       gnt_change;

    vec_t stim_q[$];
    vec_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .sel        (sel),
        .gnt_change (gnt_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [7:0] r, input logic [7:0] g, input logic [2:0] s,
                       input logic v, input logic c);
        vec_t e;
        e.req = r; e.gnt = g; e.sel = s; e.valid = v; e.change = c;
        stim_q.push_back(e);
    endtask

    // Drive every queued vector: req applied after an edge, response expected after the next one.
    task automatic run_table();
        vec_t e;
        while (stim_q.size() > 0) begin
            e = stim_q.pop_front();
            @(posedge clk);
            #2;
            req = e.req;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_direct(input string name, input logic [7:0] g, input logic [2:0] s,
                                input logic v, input logic c);
        tests_run++;
        if (gnt !== g || sel !== s || gnt_valid !== v || gnt_change !== c) begin
            tests_failed++;
            $display("[TB] FAIL %s: got gnt=%h sel=%0d valid=%b chg=%b, want gnt=%h sel=%0d valid=%b chg=%b",
                     name, gnt, sel, gnt_valid, gnt_change, g, s, v, c);
        end else begin
            $display("[TB] %s: gnt=%h sel=%0d valid=%b chg=%b ok", name, gnt, sel, gnt_valid, gnt_change);
        end
    endtask

    // Monitor: one scoreboard compare per clock while a response is outstanding.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (gnt !== e.gnt || sel !== e.sel || gnt_valid !== e.valid || gnt_change !== e.change) begin
                    tests_failed++;
                    $display("[TB] FAIL vec req=%h: got gnt=%h sel=%0d valid=%b chg=%b, want gnt=%h sel=%0d valid=%b chg=%b",
                             e.req, gnt, sel, gnt_valid, gnt_change, e.gnt, e.sel, e.valid, e.change);
                end else begin
                    $display("[TB] req=%h gnt=%h sel=%0d valid=%b chg=%b ok",
                             e.req, gnt, sel, gnt_valid, gnt_change);
                end
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        req          = 8'h00;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_direct("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle: nothing granted, no change pulses.
        for (int i = 0; i < 5; i++) add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // Lowest index from ptr=0 wins, then back-to-back hand-over with no bubble.
        add(8'h24, 8'h04, 3'd2, 1'b1, 1'b1);
        add(8'h24, 8'h04, 3'd2, 1'b1, 1'b0);
        add(8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        add(8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
        // Release to idle: sel holds 5.
        add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
        add(8'h00, 8'h00, 3'd5, 1'b0, 1'b0);
        // Wrap: owner 7, then 0 raised as 7 drops -> 0 granted, ptr becomes 1.
        add(8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
        add(8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
        add(8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
        add(8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // ptr=1 so requester 1 beats requester 0.
        add(8'h03, 8'h02, 3'd1, 1'b1, 1'b1);
        add(8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
`ifdef MUX8_ARB_PREEMPT_EN
        // ptr=2, req 0 and 3 constant: 3 for four cycles, 0 for four, then 3 again.
        add(8'h09, 8'h08, 3'd3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(8'h09, 8'h08, 3'd3, 1'b1, 1'b0);
        add(8'h09, 8'h01, 3'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(8'h09, 8'h01, 3'd0, 1'b1, 1'b0);
        add(8'h09, 8'h08, 3'd3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) add(8'h09, 8'h08, 3'd3, 1'b1, 1'b0);
`else
        // ptr=2: requester 3 granted and held for ten cycles despite requester 1 waiting.
        add(8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) add(8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);
`endif
        // Owner 3 drops: scan from 4 wraps around to requester 1.
        add(8'h02, 8'h02, 3'd1, 1'b1, 1'b1);
        add(8'h00, 8'h00, 3'd1, 1'b0, 1'b0);
        // ptr=2: requester 4 granted.
        add(8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
        add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        run_table();

        // Let the last response drain, then reset asynchronously between edges.
        @(posedge clk);
        #3;
        check_direct("pre_reset_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        rst_n = 1'b0;
        req   = 8'h00;
        #1;
        check_direct("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Arbitration restarts from ptr=0.
        add(8'h10, 8'h10, 3'd4, 1'b1, 1'b1);
        add(8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        add(8'h00, 8'h00, 3'd4, 1'b0, 1'b0);
        run_table();

        repeat (3) @(posedge clk);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending responses, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
